// File: rtl/mem_arbiter_if.sv
// Signal bundle around mem_arbiter: fetch port, load/store port and the shared memory bus.
// The slave modport is the arbiter's view; master is the core+memory side.
interface mem_arbiter_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [XLEN-1:0]   if_rdata;
  logic              if_ack;

  logic              ls_re;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [XLEN-1:0]   ls_wdata;
  logic [2:0]        ls_funct3;
  logic [XLEN-1:0]   ls_rdata;
  logic              ls_ack;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_be;
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_ready;

  logic              stall_F;
  logic              stall_M;

  modport slave (
    input  if_req, if_addr, ls_re, ls_we, ls_addr, ls_wdata, ls_funct3,
           mem_rdata, mem_ready,
    output if_rdata, if_ack, ls_rdata, ls_ack,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           stall_F, stall_M
  );

  modport master (
    output if_req, if_addr, ls_re, ls_we, ls_addr, ls_wdata, ls_funct3,
           mem_rdata, mem_ready,
    input  if_rdata, if_ack, ls_rdata, ls_ack,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           stall_F, stall_M
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory bus between instruction fetch and the load/store unit,
// steering store lanes and extracting/extending load data.
module mem_arbiter (
  input  logic         clk,
  input  logic         reset_n,
  mem_arbiter_if.slave bus
);
  // state  | meaning
  // IDLE   | no bus transaction outstanding
  // BUSY_I | fetch transaction on the bus, waiting for mem_ready
  // BUSY_D | load/store transaction on the bus, waiting for mem_ready
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} state_t;

  state_t      state_q;
  logic        last_d_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_be_q;
  logic        if_ack_q;
  logic        ls_ack_q;
  logic [31:0] if_rdata_q;
  logic [31:0] ls_rdata_q;
  logic [2:0]  ld_funct3_q;
  logic [1:0]  ld_off_q;

  logic        d_req, done, arb, if_cand, d_cand, grant_d, grant_i;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [1:0]  off_d;
  logic [31:0] shifted, load_d;
  logic        unused_if_lsb;

  assign unused_if_lsb = ^bus.if_addr[1:0];

  // A source is masked while its own transaction completes and in its ack
  // cycle, so a request still held from that transaction is never re-issued.
  always_comb begin
    d_req   = bus.ls_re | bus.ls_we;
    done    = (state_q != IDLE) & bus.mem_ready;
    arb     = (state_q == IDLE) | done;
    if_cand = bus.if_req & ~if_ack_q & ~(done & (state_q == BUSY_I));
    d_cand  = d_req & ~ls_ack_q & ~(done & (state_q == BUSY_D));
    grant_d = arb & d_cand & (~if_cand | ~last_d_q);
    grant_i = arb & if_cand & ~grant_d;
  end

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = bus.ls_wdata;
    off_d   = 2'b00;
    case (bus.ls_funct3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << bus.ls_addr[1:0];
        wdata_d = {4{bus.ls_wdata[7:0]}};
        off_d   = bus.ls_addr[1:0];
      end
      2'b01: begin
        be_d    = bus.ls_addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{bus.ls_wdata[15:0]}};
        off_d   = {bus.ls_addr[1], 1'b0};
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted = bus.mem_rdata >> {ld_off_q, 3'b000};
    case (ld_funct3_q)
      3'b000:  load_d = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_d = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_d = {24'h0, shifted[7:0]};
      3'b101:  load_d = {16'h0, shifted[15:0]};
      default: load_d = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_ack_q    <= 1'b0;
      ls_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      ld_funct3_q <= '0;
      ld_off_q    <= '0;
    end else begin
      if_ack_q <= done & (state_q == BUSY_I);
      ls_ack_q <= done & (state_q == BUSY_D);
      if (done && state_q == BUSY_I) if_rdata_q <= bus.mem_rdata;
      if (done && state_q == BUSY_D && !mem_we_q) ls_rdata_q <= load_d;

      if (grant_d) begin
        state_q     <= BUSY_D;
        last_d_q    <= 1'b1;
        mem_req_q   <= 1'b1;
        mem_we_q    <= bus.ls_we;
        mem_addr_q  <= {bus.ls_addr[31:2], 2'b00};
        mem_wdata_q <= wdata_d;
        mem_be_q    <= be_d;
        ld_funct3_q <= bus.ls_funct3;
        ld_off_q    <= off_d;
      end else if (grant_i) begin
        state_q    <= BUSY_I;
        last_d_q   <= 1'b0;
        mem_req_q  <= 1'b1;
        mem_we_q   <= 1'b0;
        mem_addr_q <= {bus.if_addr[31:2], 2'b00};
        mem_be_q   <= 4'b1111;
      end else if (done) begin
        state_q   <= IDLE;
        mem_req_q <= 1'b0;
      end
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.ls_ack    = ls_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ls_rdata  = ls_rdata_q;
  assign bus.stall_M   = d_req & ~ls_ack_q;
  assign bus.stall_F   = bus.if_req & ~if_ack_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random loads/stores checked
// against a byte-addressed reference memory.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mem_arbiter_if b ();
  mem_arbiter dut (.clk(clk), .reset_n(reset_n), .bus(b));

  int          passed = 0;
  int          total  = 0;
  logic [31:0] dev_mem [0:2047];
  logic [7:0]  ref_bytes [0:255];
  int          wait_mode = 0;
  bit          active = 0;
  int          wcnt = 0;
  logic [31:0] log_q [$];

  // Memory device: wait_mode fixed wait states, or random 0..2 when negative.
  always @(posedge clk) begin
    #1;
    if (!reset_n || !b.mem_req) begin
      b.mem_ready = 1'b0;
      active = 0;
    end else begin
      if (!active || b.mem_ready) begin
        active = 1;
        wcnt = (wait_mode < 0) ? int'($urandom_range(0, 2)) : wait_mode;
      end
      if (wcnt == 0) begin
        b.mem_ready = 1'b1;
        log_q.push_back(b.mem_addr);
        if (b.mem_we)
          for (int k = 0; k < 4; k++)
            if (b.mem_be[k]) dev_mem[b.mem_addr[12:2]][8*k +: 8] = b.mem_wdata[8*k +: 8];
        b.mem_rdata = dev_mem[b.mem_addr[12:2]];
      end else begin
        b.mem_ready = 1'b0;
        wcnt--;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic ls_drive(input bit re, input bit we, input logic [31:0] a,
                          input logic [2:0] f3, input logic [31:0] wd);
    b.ls_re     = re;
    b.ls_we     = we;
    b.ls_addr   = a;
    b.ls_funct3 = f3;
    b.ls_wdata  = wd;
  endtask

  task automatic wait_ack(input bit fetch, input int max, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!(fetch ? b.if_ack : b.ls_ack) && cyc < max);
    check(fetch ? "if_ack_seen" : "ls_ack_seen", 32'(fetch ? b.if_ack : b.ls_ack), 32'd1);
  endtask

  initial begin
    int          cyc, ls_at, if_at, n, base;
    bit          st, re;
    logic [2:0]  f3;
    logic [31:0] a, wd, exp_v;
    logic [3:0]  exp_be;
    logic [31:0] exp_seq [4];

    reset_n = 1'b0;
    b.if_req = 0; b.if_addr = 0;
    ls_drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 256; i++) ref_bytes[i] = 8'($urandom);
    for (int i = 0; i < 64; i++)
      dev_mem[i] = {ref_bytes[4*i+3], ref_bytes[4*i+2], ref_bytes[4*i+1], ref_bytes[4*i]};
    dev_mem[32'h100 >> 2]  = 32'h00500093;
    dev_mem[32'h200 >> 2]  = 32'h80FF1234;
    dev_mem[32'h204 >> 2]  = 32'h13579BDF;
    dev_mem[32'h208 >> 2]  = 32'h2468ACE0;
    dev_mem[32'h20C >> 2]  = 32'h0BADF00D;
    dev_mem[32'h300 >> 2]  = 32'h11223344;
    dev_mem[32'h1000 >> 2] = 32'h00A00113;
    dev_mem[32'h1004 >> 2] = 32'h00B00193;
    dev_mem[32'h1008 >> 2] = 32'h00C00213;

    // Reset state
    repeat (2) tick();
    check("rst_mem_req", b.mem_req, 0);
    check("rst_mem_addr", b.mem_addr, 0);
    check("rst_mem_wdata", b.mem_wdata, 0);
    check("rst_ctl", {b.mem_we, b.mem_be, b.if_ack, b.ls_ack}, 0);
    check("rst_rdata", b.if_rdata | b.ls_rdata, 0);
    reset_n = 1'b1;
    tick();

    // LB sign-extended from lane 3
    wait_mode = 0;
    ls_drive(1, 0, 32'h203, 3'b000, 0);
    tick();
    check("lb_mem_req", b.mem_req, 1);
    check("lb_mem_addr", b.mem_addr, 32'h200);
    check("lb_be", b.mem_be, 4'b1000);
    check("lb_we", b.mem_we, 0);
    check("lb_stall_M", b.stall_M, 1);
    wait_ack(0, 10, cyc);
    check("lb_latency", cyc, 1);
    check("lb_rdata", b.ls_rdata, 32'hFFFFFF80);
    check("lb_stall_M_ack", b.stall_M, 0);
    ls_drive(0, 0, 0, 0, 0);
    tick();

    // LHU from upper half
    ls_drive(1, 0, 32'h202, 3'b101, 0);
    tick();
    check("lhu_be", b.mem_be, 4'b1100);
    wait_ack(0, 10, cyc);
    check("lhu_rdata", b.ls_rdata, 32'h000080FF);
    ls_drive(0, 0, 0, 0, 0);
    tick();

    // SB lane replication
    ls_drive(0, 1, 32'h301, 3'b000, 32'hDEADBEAB);
    tick();
    check("sb_wdata", b.mem_wdata, 32'hABABABAB);
    check("sb_be", b.mem_be, 4'b0010);
    check("sb_we", b.mem_we, 1);
    check("sb_addr", b.mem_addr, 32'h300);
    wait_ack(0, 10, cyc);
    ls_drive(0, 0, 0, 0, 0);
    tick();
    check("sb_mem_word", dev_mem[32'h300 >> 2], 32'h1122AB44);

    // Fetch only, zero wait
    b.if_req = 1; b.if_addr = 32'h100;
    #1;
    check("f_stall_c0", b.stall_F, 1);
    tick();
    check("f_mem_req_c1", b.mem_req, 1);
    check("f_be_c1", b.mem_be, 4'hF);
    check("f_we_c1", b.mem_we, 0);
    check("f_addr_c1", b.mem_addr, 32'h100);
    check("f_stall_c1", b.stall_F, 1);
    check("f_ack_c1", b.if_ack, 0);
    tick();
    check("f_ack_c2", b.if_ack, 1);
    check("f_rdata_c2", b.if_rdata, 32'h00500093);
    check("f_stall_c2", b.stall_F, 0);
    check("f_no_regrant", b.mem_req, 0);
    b.if_req = 0;
    tick();
    check("f_ack_c3", b.if_ack, 0);

    // Contention with two wait states per access
    wait_mode = 2;
    log_q.delete();
    ls_at = 0; if_at = 0;
    b.if_req = 1; b.if_addr = 32'h1000;
    ls_drive(1, 0, 32'h204, 3'b010, 0);
    for (int c = 1; c <= 20 && if_at == 0; c++) begin
      tick();
      if (b.ls_ack) begin
        ls_at = c;
        b.ls_re = 0;
        check("cont_ls_rdata", b.ls_rdata, 32'h13579BDF);
      end
      if (b.if_ack) begin
        if_at = c;
        b.if_req = 0;
        check("cont_if_rdata", b.if_rdata, 32'h00A00113);
      end else begin
        check("cont_stall_F", b.stall_F, 1);
        check("cont_mem_req", b.mem_req, 1);
      end
    end
    check("cont_ls_ack_cycle", ls_at, 4);
    check("cont_if_ack_cycle", if_at, 7);
    check("cont_grants", log_q.size(), 2);
    check("cont_first_d", log_q.size() > 0 ? log_q[0] : 32'hFFFFFFFF, 32'h204);
    check("cont_second_i", log_q.size() > 1 ? log_q[1] : 32'hFFFFFFFF, 32'h1000);
    tick();

    // Anti-starvation: data re-requests right after each ack while fetch is held
    wait_mode = 0;
    log_q.delete();
    b.if_req = 1; b.if_addr = 32'h1004;
    ls_drive(1, 0, 32'h208, 3'b010, 0);
    for (int c = 0; c < 40 && log_q.size() < 4; c++) begin
      tick();
      b.ls_re = !b.ls_ack;
    end
    b.if_req = 0; b.ls_re = 0;
    repeat (3) tick();
    exp_seq = '{32'h208, 32'h1004, 32'h208, 32'h1004};
    for (int i = 0; i < 4; i++)
      check($sformatf("alt_grant%0d", i), i < log_q.size() ? log_q[i] : 32'hFFFFFFFF, exp_seq[i]);

    // Reset mid-transaction
    wait_mode = 5;
    ls_drive(1, 0, 32'h20C, 3'b010, 0);
    tick();
    tick();
    check("rm_busy", b.mem_req, 1);
    reset_n = 1'b0;
    #1;
    check("rm_mem_req", b.mem_req, 0);
    check("rm_mem_addr", b.mem_addr, 0);
    check("rm_ctl", {b.mem_we, b.mem_be, b.if_ack, b.ls_ack}, 0);
    check("rm_wdata", b.mem_wdata, 0);
    check("rm_if_rdata", b.if_rdata, 0);
    check("rm_ls_rdata", b.ls_rdata, 0);
    ls_drive(0, 0, 0, 0, 0);
    b.if_req = 1; b.if_addr = 32'h1008;
    wait_mode = 0;
    tick();
    reset_n = 1'b1;
    tick();
    check("rm_f_req_c1", b.mem_req, 1);
    check("rm_f_addr_c1", b.mem_addr, 32'h1008);
    check("rm_f_we_c1", b.mem_we, 0);
    tick();
    check("rm_f_ack_c2", b.if_ack, 1);
    check("rm_f_rdata", b.if_rdata, 32'h00C00213);
    b.if_req = 0;
    tick();

    // Random loads/stores against the byte-level reference memory
    wait_mode = -1;
    for (int t = 0; t < 40; t++) begin
      st = 1'($urandom_range(0, 1));
      if (st) begin
        f3 = 3'($urandom_range(0, 2));
        re = 1'($urandom_range(0, 1));
      end else begin
        re = 1;
        case ($urandom_range(0, 4))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end
      a  = 32'($urandom_range(0, 255));
      wd = $urandom;
      n  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      base = int'(a) - (int'(a) % n);
      exp_be = 4'b0000;
      for (int k = 0; k < n; k++) exp_be[(base + k) % 4] = 1'b1;
      ls_drive(re, st, a, f3, wd);
      tick();
      check("rnd_addr", b.mem_addr, 32'(base - base % 4));
      check("rnd_be", b.mem_be, exp_be);
      check("rnd_we", b.mem_we, st);
      check("rnd_stall_M", b.stall_M, 1);
      if (st)
        for (int k = 0; k < n; k++)
          check("rnd_wlane", b.mem_wdata[8*((base + k) % 4) +: 8], wd[8*k +: 8]);
      wait_ack(0, 12, cyc);
      if (st) begin
        for (int k = 0; k < n; k++) ref_bytes[base + k] = wd[8*k +: 8];
      end else begin
        exp_v = 0;
        for (int k = 0; k < n; k++) exp_v = exp_v | (32'(ref_bytes[base + k]) << (8 * k));
        if (!f3[2] && n < 4 && exp_v[8*n-1]) exp_v = exp_v | (32'hFFFFFFFF << (8 * n));
        check("rnd_ls_rdata", b.ls_rdata, exp_v);
      end
      ls_drive(0, 0, 0, 0, 0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port memory arbiter and sequencer for the unified instruction/data bus.
- Shares one memory interface between instruction fetch (IF) and the load/store unit (LSU).
- Generates byte enables, aligns and sign-extends load data, and drives the fetch and memory-stage stall signals consumed by the pipeline.
- Sits between the core (fetch stage, memory stage) and the external memory.

Parameters:
XLEN  32  data width; only 32 supported (4 byte lanes)
ADDR_W  32  address width

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous, active-low
if_req  in  1  fetch request; held until if_ack
if_addr  in  ADDR_W  fetch address (word aligned)
if_rdata  out  XLEN  fetched instruction word
if_ack  out  1  one-cycle fetch completion pulse
ls_re  in  1  load request; held until ls_ack
ls_we  in  1  store request; held until ls_ack
ls_addr  in  ADDR_W  load/store byte address
ls_wdata  in  XLEN  store data (LSB-aligned)
ls_funct3  in  3  access size/sign (RV32 load/store funct3)
ls_rdata  out  XLEN  aligned, extended load data
ls_ack  out  1  one-cycle load/store completion pulse
mem_req  out  1  bus request; held until mem_ready
mem_we  out  1  bus write
mem_addr  out  ADDR_W  bus address, low 2 bits zero
mem_wdata  out  XLEN  lane-replicated write data
mem_be  out  XLEN/8  byte enables
mem_rdata  in  XLEN  bus read data, valid with mem_ready
mem_ready  in  1  bus completion
stall_F  out  1  fetch must hold
stall_M  out  1  memory stage must hold

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D.
- Arbitration occurs in IDLE, or in the completion cycle of a busy state (mem_req & mem_ready).
- Arbitration rules:
  - Data request = ls_re | ls_we. If both ls_re and ls_we are set, the access is a store.
  - Only a data request → BUSY_D. Only if_req → BUSY_I.
  - Both pending → BUSY_D, unless the last granted transaction was data; then BUSY_I (anti-starvation flag last_d, reset 0).
  - No request → IDLE.
- On grant, mem_req/mem_we/mem_addr/mem_wdata/mem_be are registered and held stable until mem_ready is sampled high.
- No combinational path exists from requester inputs to mem_* outputs.
- Completion:
  - In BUSY_x with mem_ready=1, the next cycle pulses the matching ack for exactly 1 cycle.
  - if_rdata/ls_rdata are registered at the same edge and hold until the next completion.
  - mem_req deasserts at that edge unless a new grant occurs, in which case it stays high with new fields (back-to-back).
- Latency: request sampled in cycle N → mem_req in N+1 → with zero-wait memory, ack in N+2. Each wait cycle (mem_ready=0) adds 1.
- Suppressing re-grant of an acked requester:
  - The requester drops its request in the ack cycle.
  - The arbiter does not re-grant a source in the cycle after its completion (the request is masked for that one arbitration).
- Byte enables (ls_funct3[1:0]):
  - 00: be = 1 << addr[1:0].
  - 01: be = 2'b11 << {addr[1],1'b0}.
  - 10/11: be = 4'b1111.
  - Fetch: be = 4'b1111, mem_we = 0.
- Write data: byte access replicates wdata[7:0] ×4; half replicates wdata[15:0] ×2; word passes through.
- Load extraction:
  - Shift mem_rdata right by 8×addr[1:0] (half: 16×addr[1]).
  - 000 LB sign-extend byte; 001 LH sign-extend half; 010 LW word.
  - 100 LBU / 101 LHU zero-extend; others treated as word.
- Misaligned access: low bits are masked per size (half ignores addr[0]; word ignores addr[1:0]). No trap is raised.
- Stalls (combinational):
  - stall_M = (ls_re|ls_we) & ~ls_ack.
  - stall_F = if_req & ~if_ack.
- Request dropped mid-transaction (e.g. flush): the transaction still completes and the ack still pulses; the requester ignores it.
- Reset:
  - Asynchronous; aborts any transaction.
  - State IDLE; all outputs 0: mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_ack, ls_ack, if_rdata, ls_rdata; last_d = 0.
  - The memory must tolerate an abandoned request.

Test Plan:
- Fetch only, zero-wait:
  - Stimulus: if_req=1, if_addr=0x100, mem_ready tied 1, mem_rdata=0x00500093.
  - Required: mem_req at cycle 1 with be=4'hF, we=0; if_ack and if_rdata=0x00500093 at cycle 2; stall_F high cycles 0-1.
- LB sign and LHU:
  - LB: ls_re, ls_funct3=000, addr=0x203, mem_rdata=0x80FF1234 → mem_addr=0x200, be=4'b1000, ls_rdata=0xFFFFFF80.
  - LHU: funct3=101, addr=0x202 → be=4'b1100, ls_rdata=0x000080FF.
- SB lane replication:
  - Stimulus: ls_we, funct3=000, addr=0x301, wdata=0xDEADBEAB.
  - Required: mem_wdata=0xABABABAB, be=4'b0010, mem_we=1.
- Contention with wait states:
  - Stimulus: if_req and ls_re both held; mem_ready low 2 cycles per access.
  - Required: data granted first; fetch granted back-to-back after ls_ack (mem_req stays high); stall_F stays high throughout.
- Anti-starvation:
  - Stimulus: ls_re reasserted immediately after each ack while if_req is held.
  - Required: grants alternate D, I, D, I.
- Reset mid-operation:
  - Stimulus: assert reset_n=0 while BUSY_D with mem_ready=0.
  - Required: all outputs 0 asynchronously; after release with if_req=1, the first grant is fetch with correct 2-cycle latency.
